// File: rtl/scan_displayer_p_if.sv
// scan_displayer_p_if: display-side bus for the multi-field 7-seg scanner.
// master drives en/values/blink_mask/dp_mask; slave drives select_dig/select_seg/frame_start.
interface scan_displayer_p_if #(
  parameter int N_FIELDS = 3,
  parameter int DIG_W    = 8
);
  logic                    en;
  logic [6*N_FIELDS-1:0]   values;
  logic [N_FIELDS-1:0]     blink_mask;
  logic [2*N_FIELDS-1:0]   dp_mask;
  logic [DIG_W-1:0]        select_dig;
  logic [7:0]              select_seg;
  logic                    frame_start;

  modport master (
    output en, values, blink_mask, dp_mask,
    input  select_dig, select_seg, frame_start
  );

  modport slave (
    input  en, values, blink_mask, dp_mask,
    output select_dig, select_seg, frame_start
  );
endinterface

// File: rtl/scan_displayer_p.sv
// scan_displayer_p: multiplexes N_FIELDS two-digit values onto a 7-seg display.
// Ports: clk_1000hz, rst (sync, active high), bus (slave: en/values/masks in, dig/seg/frame_start out).
module scan_displayer_p #(
  parameter int                  N_FIELDS       = 3,
  parameter int                  DIG_W          = 8,
  parameter int                  DWELL          = 1,
  parameter int                  DEAD_CYCLES    = 0,
  parameter int                  BLINK_HALF     = 500,
  parameter bit                  DIG_ACTIVE_LOW = 1'b1,
  parameter bit                  SEG_ACTIVE_LOW = 1'b0,
  parameter logic [N_FIELDS-1:0] LZB_MASK       = '0
) (
  input logic clk_1000hz,
  input logic rst,
  scan_displayer_p_if.slave bus
);

  localparam int NS   = 2 * N_FIELDS;
  localparam int SW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int FW   = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int CMAX = (DWELL > DEAD_CYCLES) ? DWELL : DEAD_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DM1  = (DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0;

  localparam logic [SW-1:0]    SLOT_LAST = SW'(NS - 1);
  localparam logic [CW-1:0]    DWELL_END = CW'(DWELL - 1);
  localparam logic [CW-1:0]    DEAD_END  = CW'(DM1);
  localparam logic [BW-1:0]    BLINK_END = BW'(BLINK_HALF - 1);
  localparam logic [DIG_W-1:0] DIG_OFF   = {DIG_W{DIG_ACTIVE_LOW}};
  localparam logic [7:0]       SEG_OFF   = {8{SEG_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_DEAD
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         slot_q, slot_d, slot_nx;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [6*N_FIELDS-1:0] shadow_q, shadow_d;
  logic [DIG_W-1:0]      dig_q, dig_d, dig_raw;
  logic [7:0]            seg_q, seg_d, seg_raw;
  logic                  fs_q, fs_d;

  logic                  frame_d;
  logic [FW-1:0]         fidx;
  logic [5:0]            fval;
  logic                  hi, oor, blank;
  logic [3:0]            digit;
  logic [6:0]            seg7;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign slot_nx = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    if (!bus.en) begin
      state_d = S_IDLE;
      slot_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ON;
          slot_d  = '0;
          cnt_d   = '0;
        end
        S_ON: begin
          if (cnt_q == DWELL_END) begin
            cnt_d = '0;
            if (DEAD_CYCLES > 0) state_d = S_DEAD;
            else                 slot_d  = slot_nx;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DEAD: begin
          if (cnt_q == DEAD_END) begin
            cnt_d   = '0;
            state_d = S_ON;
            slot_d  = slot_nx;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          slot_d  = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (bcnt_q == BLINK_END) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  // Outputs are registered from the next state, so select and segment
  // data move together. Slot 0 of a fresh frame reads values directly,
  // which is exactly what the shadow captures on that same edge.
  always_comb begin
    frame_d  = (state_d == S_ON) && (slot_d == '0) &&
               !((state_q == S_ON) && (slot_q == '0));
    shadow_d = frame_d ? bus.values : shadow_q;

    fidx  = FW'(slot_d >> 1);
    hi    = slot_d[0];
    fval  = shadow_d[6*fidx +: 6];
    oor   = (fval >= 6'd60);
    digit = hi ? 4'(fval / 6'd10) : 4'(fval % 6'd10);
    seg7  = oor ? 7'h40 : seg_of(digit);
    blank = (LZB_MASK[fidx] && hi && !oor && (digit == 4'd0)) ||
            (phase_d && bus.blink_mask[fidx]);

    seg_raw = blank ? 8'h00 : {bus.dp_mask[slot_d], seg7};
    dig_raw = DIG_W'(1) << slot_d;

    dig_d = DIG_OFF;
    seg_d = SEG_OFF;
    fs_d  = 1'b0;
    if (state_d == S_ON) begin
      dig_d = dig_raw ^ DIG_OFF;
      seg_d = seg_raw ^ SEG_OFF;
      fs_d  = frame_d;
    end
  end

  always_ff @(posedge clk_1000hz) begin
    if (rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      dig_q    <= DIG_OFF;
      seg_q    <= SEG_OFF;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      dig_q    <= dig_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.select_dig  = dig_q;
  assign bus.select_seg  = seg_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_scan_displayer_p.sv
// tb_scan_displayer_p: table and sequence checks for scan_displayer_p.
// Four instances cover default scan, dwell/dead, blink and blanking/dp.
module tb_scan_displayer_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  scan_displayer_p_if b0 ();
  scan_displayer_p_if b1 ();
  scan_displayer_p_if b2 ();
  scan_displayer_p_if b3 ();

  scan_displayer_p u0 (
    .clk_1000hz(clk), .rst(rst), .bus(b0.slave)
  );
  scan_displayer_p #(.DWELL(2), .DEAD_CYCLES(1)) u1 (
    .clk_1000hz(clk), .rst(rst), .bus(b1.slave)
  );
  scan_displayer_p #(.BLINK_HALF(4)) u2 (
    .clk_1000hz(clk), .rst(rst), .bus(b2.slave)
  );
  scan_displayer_p #(.LZB_MASK(3'b100)) u3 (
    .clk_1000hz(clk), .rst(rst), .bus(b3.slave)
  );

  logic [7:0] odig [4];
  logic [7:0] oseg [4];
  logic       ofs  [4];

  assign odig[0] = b0.select_dig;
  assign odig[1] = b1.select_dig;
  assign odig[2] = b2.select_dig;
  assign odig[3] = b3.select_dig;
  assign oseg[0] = b0.select_seg;
  assign oseg[1] = b1.select_seg;
  assign oseg[2] = b2.select_seg;
  assign oseg[3] = b3.select_seg;
  assign ofs[0]  = b0.frame_start;
  assign ofs[1]  = b1.frame_start;
  assign ofs[2]  = b2.frame_start;
  assign ofs[3]  = b3.frame_start;

  typedef struct {
    string      nm;
    int         inst;
    logic [7:0] dig;
    logic [7:0] seg;
    logic       fs;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        en;
    logic [17:0] vals;
    logic [7:0]  dig;
    logic [7:0]  seg;
    logic        fs;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string nm, input int inst,
                      input logic [7:0] d, input logic [7:0] s,
                      input logic f);
    exp_t e;
    e.nm   = nm;
    e.inst = inst;
    e.dig  = d;
    e.seg  = s;
    e.fs   = f;
    sb.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.nm, " dig"}, odig[e.inst], e.dig);
      cmp({e.nm, " seg"}, oseg[e.inst], e.seg);
      cmp({e.nm, " fs"}, {7'd0, ofs[e.inst]}, {7'd0, e.fs});
    end
  endtask

  task automatic do_reset(input int inst);
    rst = 1'b1;
    push($sformatf("reset u%0d", inst), inst, 8'hFF, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  localparam logic [17:0] V0 = {6'd12, 6'd5, 6'd37};
  localparam logic [17:0] V1 = {6'd23, 6'd5, 6'd38};

  vec_t       va [24];
  logic [7:0] segtab [6];
  logic [7:0] lzbtab [6];

  initial begin
    logic [7:0] d, s;
    logic       f, bl;
    int         p, sl;

    va[0]  = '{1'b0, 1'b1, V0, 8'hFE, 8'h07, 1'b1};
    va[1]  = '{1'b0, 1'b1, V0, 8'hFD, 8'h4F, 1'b0};
    va[2]  = '{1'b0, 1'b1, V1, 8'hFB, 8'h6D, 1'b0};
    va[3]  = '{1'b0, 1'b1, V1, 8'hF7, 8'h3F, 1'b0};
    va[4]  = '{1'b0, 1'b1, V1, 8'hEF, 8'h5B, 1'b0};
    va[5]  = '{1'b0, 1'b1, V1, 8'hDF, 8'h06, 1'b0};
    va[6]  = '{1'b0, 1'b1, V1, 8'hFE, 8'h7F, 1'b1};
    va[7]  = '{1'b0, 1'b1, V1, 8'hFD, 8'h4F, 1'b0};
    va[8]  = '{1'b0, 1'b1, V1, 8'hFB, 8'h6D, 1'b0};
    va[9]  = '{1'b0, 1'b1, V1, 8'hF7, 8'h3F, 1'b0};
    va[10] = '{1'b0, 1'b1, V1, 8'hEF, 8'h4F, 1'b0};
    va[11] = '{1'b0, 1'b1, V1, 8'hDF, 8'h5B, 1'b0};
    va[12] = '{1'b0, 1'b1, V1, 8'hFE, 8'h7F, 1'b1};
    va[13] = '{1'b0, 1'b1, V1, 8'hFD, 8'h4F, 1'b0};
    va[14] = '{1'b0, 1'b1, V1, 8'hFB, 8'h6D, 1'b0};
    va[15] = '{1'b0, 1'b1, V1, 8'hF7, 8'h3F, 1'b0};
    va[16] = '{1'b0, 1'b0, V1, 8'hFF, 8'h00, 1'b0};
    va[17] = '{1'b0, 1'b0, V1, 8'hFF, 8'h00, 1'b0};
    va[18] = '{1'b0, 1'b1, V1, 8'hFE, 8'h7F, 1'b1};
    va[19] = '{1'b0, 1'b1, V1, 8'hFD, 8'h4F, 1'b0};
    va[20] = '{1'b0, 1'b1, V1, 8'hFB, 8'h6D, 1'b0};
    va[21] = '{1'b1, 1'b1, V1, 8'hFF, 8'h00, 1'b0};
    va[22] = '{1'b0, 1'b1, V1, 8'hFE, 8'h7F, 1'b1};
    va[23] = '{1'b0, 1'b1, V1, 8'hFD, 8'h4F, 1'b0};

    segtab = '{8'h07, 8'h4F, 8'h6D, 8'h3F, 8'h5B, 8'h06};
    lzbtab = '{8'h40, 8'h40, 8'hED, 8'h3F, 8'h07, 8'h00};

    rst = 1'b1;
    b0.en = 1'b0; b0.values = '0; b0.blink_mask = '0; b0.dp_mask = '0;
    b1.en = 1'b0; b1.values = '0; b1.blink_mask = '0; b1.dp_mask = '0;
    b2.en = 1'b0; b2.values = '0; b2.blink_mask = '0; b2.dp_mask = '0;
    b3.en = 1'b0; b3.values = '0; b3.blink_mask = '0; b3.dp_mask = '0;

    // default scan, frame coherence, en drop and mid-scan reset
    do_reset(0);
    for (int i = 0; i < 24; i++) begin
      rst       = va[i].rst;
      b0.en     = va[i].en;
      b0.values = va[i].vals;
      push($sformatf("u0 vec%0d", i), 0, va[i].dig, va[i].seg, va[i].fs);
      tick();
    end
    rst   = 1'b0;
    b0.en = 1'b0;

    // dwell 2 + dead 1: 18-cycle period
    do_reset(1);
    b1.values = V0;
    b1.en     = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      p  = (c - 1) % 3;
      sl = ((c - 1) / 3) % 6;
      d  = 8'h01 << sl;
      d  = (p < 2) ? ~d : 8'hFF;
      s  = (p < 2) ? segtab[sl] : 8'h00;
      f  = (p == 0) && (sl == 0);
      push($sformatf("u1 cyc%0d", c), 1, d, s, f);
      tick();
    end
    b1.en = 1'b0;

    // blink on minutes field, half period 4
    do_reset(2);
    b2.values     = V0;
    b2.blink_mask = 3'b010;
    b2.en         = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      sl = (c - 1) % 6;
      bl = (((c / 4) % 2) == 1) && ((sl == 2) || (sl == 3));
      d  = 8'h01 << sl;
      d  = ~d;
      s  = bl ? 8'h00 : segtab[sl];
      f  = (sl == 0);
      push($sformatf("u2 cyc%0d", c), 2, d, s, f);
      tick();
    end
    b2.en = 1'b0;

    // leading-zero blank on hour, out-of-range sec, dp masks
    do_reset(3);
    b3.values  = {6'd7, 6'd5, 6'd61};
    b3.dp_mask = 6'b000100;
    b3.en      = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (c == 7) b3.dp_mask = 6'b100100;
      sl = (c - 1) % 6;
      d  = 8'h01 << sl;
      d  = ~d;
      push($sformatf("u3 cyc%0d", c), 3, d, lzbtab[sl], sl == 0);
      tick();
    end
    b3.en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_displayer_p.md
Name: scan_displayer_p

Overview:
- Parametrised successor to the fixed 3-field, 6-digit time scanner.
- Multiplexes N_FIELDS two-digit values (0..59 range, 6-bit) onto a DIG_W-position common-select 7-segment display.
- Adds frame-coherent value sampling, configurable dwell/dead time, per-field blink, per-digit decimal point, leading-zero blanking and out-of-range indication.
- Sits between the clock/alarm state core and the board display pins; it is purely a viewer and exerts no control on time state.

Parameters:
- N_FIELDS, 3, number of 6-bit fields; field 0 is the rightmost, e.g. seconds.
- DIG_W, 8, physical digit-select width; must satisfy DIG_W >= 2*N_FIELDS.
- DWELL, 1, cycles each digit is lit per visit; >= 1.
- DEAD_CYCLES, 0, all-off cycles inserted after each digit (anti-ghosting); 0 = none.
- BLINK_HALF, 500, cycles per blink half-period.
- DIG_ACTIVE_LOW, 1, 1 = select_dig bit 0 means lit.
- SEG_ACTIVE_LOW, 0, 1 = select_seg inverted.
- LZB_MASK, 0, N_FIELDS-bit mask; set bit i blanks field i's high digit when it is 0.

Ports:
- clk_1000hz  in  1  scan clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable.
- values  in  6*N_FIELDS  field i = values[6i+5:6i].
- blink_mask  in  N_FIELDS  fields to blink.
- dp_mask  in  2*N_FIELDS  bit k lights the decimal point on slot k.
- select_dig  out  DIG_W  registered digit select.
- select_seg  out  8  registered segments; bit7 = dp, bits6:0 = g..a.
- frame_start  out  1  one-cycle pulse on the first lit cycle of slot 0.

Behaviour:
- Reset, one clock with rst=1:
  - select_dig and select_seg are all-off (polarity applied).
  - frame_start = 0; slot = 0; dwell/dead counters = 0; FSM = IDLE; blink counter = 0; blink phase = 0; shadow register = 0.
- Reset mid-scan aborts the current slot. The next visible digit is always slot 0.
- Slot k (0..2N-1) drives digit position k, showing field k/2:
  - even k = low (units) digit;
  - odd k = high (tens) digit.
  - Positions >= 2N are never lit.
- FSM states: IDLE, ON, DEAD.
  - IDLE: outputs all-off. When en=1, the next edge enters ON with slot 0.
  - ON: holds for DWELL cycles. If DEAD_CYCLES > 0, then DEAD for DEAD_CYCLES cycles; otherwise go directly to ON with slot+1.
  - Slot 2N-1 wraps to slot 0.
  - Any state with en=0 goes to IDLE next edge, with outputs off on that edge.
- Frame sampling: on the edge entering ON with slot 0, `values` is latched into the shadow register.
  - Slot 0 of that visit is decoded from the input itself.
  - All other slots use the shadow, so no torn display occurs across a 59 -> 00 rollover mid-frame.
  - frame_start = 1 for exactly that cycle.
- select_dig and select_seg always change on the same edge; there is no skew between select and segment data.
- Scan period = 2N*(DWELL+DEAD_CYCLES) cycles.
- Decode, active-high before polarity:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Field value 60..63: both digits show dash 40; leading-zero blanking is not applied.
- Blanking: a digit blanked by leading-zero or blink drives segments all-off, including dp. select_dig is still driven.
- Blink counter:
  - Free-runs whenever not in reset, including while en=0.
  - Toggles blink phase on reaching BLINK_HALF-1, then returns to 0.
  - Phase 1 blanks both digits of every field with its blink_mask bit set.
  - blink_mask is sampled live, not shadowed.
- dp_mask is sampled live. dp is ORed into bit7 unless the digit is blanked.
- SEG_ACTIVE_LOW / DIG_ACTIVE_LOW are applied as a final inversion. The all-off value is the inverted zero.

Test Plan:
- Defaults; values = {hour 12, min 05, sec 37}; en = 1 after reset.
  - Cycles 1..6 after release: select_dig FE,FD,FB,F7,EF,DF.
  - select_seg 07,4F,6D,3F,5B,06.
  - frame_start high only on cycle 1 and cycle 7.
- Coherence: sec changes 37 -> 38 on cycle 3.
  - Slots 0..5 of the current frame still show 37 for sec and 12:05 for the other fields.
  - Slot 0 of the next frame (cycle 7) shows 08.
- DWELL=2, DEAD_CYCLES=1: each select_dig value is held 2 cycles, then 1 cycle of FF/00; period 18 cycles.
- Blink: BLINK_HALF=4, blink_mask=010.
  - Slots 2,3 output 00 during cycles 4..7, 12..15, ...
  - The sec and hour fields are unaffected.
- LZB_MASK=100, hour=07, sec=61.
  - Slot 5 blank (00); slot 4 shows 07.
  - Slots 0,1 show 40.
  - dp_mask=000100 lights bit7 on slot 2 only.
- en deasserted mid slot 3 → outputs all-off the next edge.
  - Re-enable → slot 0 first, with frame_start pulse.
  - rst during ON → all-off the next edge, same restart behaviour.
